serial_word_deserializer: RTL

//   Downstream consumer of the master-slave D flip-flop stage: samples its serial q output into

---
 rtl/serial_word_deserializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: collects serial bits into WIDTH-bit words and
// hands each word to a one-deep holding register with a valid/ready handshake.
// Optional even-parity bit per frame, enabled by the DESER_PARITY_EN macro.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   COLLECT | shifting in data bits; bit_cnt counts bits of current word
//   CHECK   | data bits complete, waiting for the parity bit (parity build)
//
// Without DESER_PARITY_EN the design only ever collects, so no state
// register is built and a word is delivered on its last data bit.
module serial_word_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    output logic             parity_err
);

    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef DESER_PARITY_EN
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] CHECK   = 1'b1;
    logic [0:0] state;
`endif

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] new_word;
    logic             complete;
    logic             can_load;

    // Next shift-chain value with the current bit inserted per bit order
    always_comb begin
        if (MSB_FIRST) begin
            shift_next = {shift_reg[WIDTH-2:0], d};
        end else begin
            shift_next = {d, shift_reg[WIDTH-1:1]};
        end
    end

    // Frame completion and the word it produces; holding register may load
    // when empty or when its current word is being consumed this edge
    always_comb begin
        complete = 1'b0;
        new_word = shift_next;
`ifdef DESER_PARITY_EN
        if (state == CHECK) begin
            complete = d_valid;
            new_word = shift_reg;
        end
`else
        complete = d_valid && (bit_cnt == CNT_LAST);
`endif
        can_load = !word_valid || word_ready;
    end

    // Serial capture: shift chain, bit counter and frame state
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef DESER_PARITY_EN
            state     <= COLLECT;
`endif
        end else if (d_valid) begin
`ifdef DESER_PARITY_EN
            if (state == COLLECT) begin
                shift_reg <= shift_next;
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt <= '0;
                    state   <= CHECK;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else begin
                state <= COLLECT;
            end
`else
            shift_reg <= shift_next;
            if (bit_cnt == CNT_LAST) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
`endif
        end
    end

    // Holding register handshake; a blocked completion is dropped and flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (complete) begin
                if (can_load) begin
                    word_out   <= new_word;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

`ifdef DESER_PARITY_EN
    // Even parity over data plus parity bit; dropped words are checked too
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (complete && ((^shift_reg) ^ d)) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
